// File: rtl/fulladd4_resp_checker.sv
// fulladd4_resp_checker: computes the golden a+b+cin, aligns it to the adder response and scores SUM/C_OUT.
// Latency: in_valid at cycle N gives a chk_valid pulse at cycle N+LAT+1; throughput 1 vector/cycle.
// Backpressure: none, a vector is accepted every cycle. FA4CHK_FAIL_CAPTURE_EN builds the fail_* capture.
module fulladd4_resp_checker #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    input  logic             clear,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_cout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Operands only travel down the pipe when something downstream records them.
    typedef struct packed {
        logic             vld;
`ifdef FA4CHK_FAIL_CAPTURE_EN
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
`endif
        logic [WIDTH:0]   exp_res;
    } stage_t;

    stage_t in_stage;
    stage_t cmp;
    logic   match;

    always_comb begin
        in_stage         = '0;
        in_stage.vld     = in_valid & ~clear;
`ifdef FA4CHK_FAIL_CAPTURE_EN
        in_stage.a       = in_a;
        in_stage.b       = in_b;
        in_stage.cin     = in_cin;
`endif
        in_stage.exp_res = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
    end

    if (LAT == 0) begin : g_direct
        assign cmp = in_stage;
    end else begin : g_pipe
        stage_t pipe_q [LAT];

        // Payload is left untouched on reset/clear; only the valid bits matter.
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                for (int i = 0; i < LAT; i++) begin
                    pipe_q[i].vld <= 1'b0;
                end
            end else begin
                pipe_q[0] <= in_stage;
                for (int i = 1; i < LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign cmp = pipe_q[LAT-1];
    end

    assign match = ({dut_cout, dut_sum} == cmp.exp_res);

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_valid  <= 1'b0;
            chk_pass   <= 1'b0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clear) begin
            chk_valid  <= 1'b0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            chk_valid <= cmp.vld;
            if (cmp.vld) begin
                chk_pass <= match;
                if (match) begin
                    if (pass_cnt != CNT_MAX) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end else begin
                    if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    err_sticky <= 1'b1;
                end
            end
        end
    end

`ifdef FA4CHK_FAIL_CAPTURE_EN
    // First mismatch only: the sticky flag is still 0 on the edge that records it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fail_a    <= '0;
            fail_b    <= '0;
            fail_cin  <= 1'b0;
            fail_sum  <= '0;
            fail_cout <= 1'b0;
        end else if (cmp.vld && !match && !err_sticky) begin
            fail_a    <= cmp.a;
            fail_b    <= cmp.b;
            fail_cin  <= cmp.cin;
            fail_sum  <= dut_sum;
            fail_cout <= dut_cout;
        end
    end
`else
    assign fail_a    = '0;
    assign fail_b    = '0;
    assign fail_cin  = 1'b0;
    assign fail_sum  = '0;
    assign fail_cout = 1'b0;
`endif

endmodule

// File: tb/tb_fulladd4_resp_checker.sv
// Bench for fulladd4_resp_checker: three instances (LAT=1, LAT=3, LAT=0 with 2-bit counters)
// share one operand stream; a cycle-indexed scoreboard predicts every output.
module tb_fulladd4_resp_checker;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] xs;
        logic       xc;
    } vec_t;

    typedef struct packed {
        logic       v;
        logic       p;
        logic [7:0] pc;
        logic [7:0] ec;
        logic       st;
        logic [3:0] fa;
        logic [3:0] fb;
        logic       fci;
        logic [3:0] fs;
        logic       fco;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    vec_t cur = '0;
    vec_t hist [3];

    int lats [3] = '{1, 3, 0};
    int cmax [3] = '{255, 255, 3};
    int t = 0;
    int total = 0;
    int passed = 0;

    int   sch_cyc [3][16];
    bit   sch_ok  [3][16];
    vec_t sch_vec [3][16];
    res_t mdl [3];
    res_t obs [3];

    always #5 clk = ~clk;

    // Adder stand-in: correct sum delayed by LAT, with the injected error bits applied.
    function automatic logic [4:0] resp(vec_t v);
        resp = ({1'b0, v.a} + {1'b0, v.b} + {4'b0, v.cin}) ^ {v.xc, v.xs};
    endfunction

    always @(posedge clk) begin
        hist[0] <= cur;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
    end

    logic [4:0] r0, r1, r2;
    assign r0 = resp(hist[0]);
    assign r1 = resp(hist[2]);
    assign r2 = resp(cur);

    logic       cv0, cp0, st0, fci0, fco0;
    logic       cv1, cp1, st1, fci1, fco1;
    logic       cv2, cp2, st2, fci2, fco2;
    logic [7:0] pc0, ec0, pc1, ec1;
    logic [1:0] pc2, ec2;
    logic [3:0] fa0, fb0, fs0, fa1, fb1, fs1, fa2, fb2, fs2;

    fulladd4_resp_checker #(.WIDTH(4), .LAT(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(cur.a), .in_b(cur.b),
        .in_cin(cur.cin), .dut_sum(r0[3:0]), .dut_cout(r0[4]), .clear(clear),
        .chk_valid(cv0), .chk_pass(cp0), .pass_cnt(pc0), .err_cnt(ec0), .err_sticky(st0),
        .fail_a(fa0), .fail_b(fb0), .fail_cin(fci0), .fail_sum(fs0), .fail_cout(fco0));

    fulladd4_resp_checker #(.WIDTH(4), .LAT(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(cur.a), .in_b(cur.b),
        .in_cin(cur.cin), .dut_sum(r1[3:0]), .dut_cout(r1[4]), .clear(clear),
        .chk_valid(cv1), .chk_pass(cp1), .pass_cnt(pc1), .err_cnt(ec1), .err_sticky(st1),
        .fail_a(fa1), .fail_b(fb1), .fail_cin(fci1), .fail_sum(fs1), .fail_cout(fco1));

    fulladd4_resp_checker #(.WIDTH(4), .LAT(0), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(cur.a), .in_b(cur.b),
        .in_cin(cur.cin), .dut_sum(r2[3:0]), .dut_cout(r2[4]), .clear(clear),
        .chk_valid(cv2), .chk_pass(cp2), .pass_cnt(pc2), .err_cnt(ec2), .err_sticky(st2),
        .fail_a(fa2), .fail_b(fb2), .fail_cin(fci2), .fail_sum(fs2), .fail_cout(fco2));

    assign obs[0] = {cv0, cp0, pc0, ec0, st0, fa0, fb0, fci0, fs0, fco0};
    assign obs[1] = {cv1, cp1, pc1, ec1, st1, fa1, fb1, fci1, fs1, fco1};
    assign obs[2] = {cv2, cp2, 6'd0, pc2, 6'd0, ec2, st2, fa2, fb2, fci2, fs2, fco2};

    task automatic set_in(bit v, logic [3:0] a, logic [3:0] b, bit cin, logic [3:0] xs, bit xc);
        in_valid = v;
        cur = '{a: a, b: b, cin: cin, xs: xs, xc: xc};
    endtask

    // Advance one clock and update the scoreboard from what was presented during that cycle.
    task automatic step();
        bit   kill, hard, keep_p;
        int   cyc, s;
        vec_t v;
        logic [4:0] r;
        kill = clear || reset;
        hard = reset;
        if (in_valid && !kill) begin
            for (int d = 0; d < 3; d++) begin
                cyc = t + lats[d] + 1;
                s = cyc % 16;
                sch_cyc[d][s] = cyc;
                sch_ok[d][s]  = (cur.xs == 4'd0) && !cur.xc;
                sch_vec[d][s] = cur;
            end
        end
        @(posedge clk);
        #1;
        t++;
        for (int d = 0; d < 3; d++) begin
            s = t % 16;
            if (kill) begin
                for (int k = 0; k < 16; k++) if (sch_cyc[d][k] >= t) sch_cyc[d][k] = -1;
                keep_p = mdl[d].p;
                mdl[d] = '0;
                if (!hard) mdl[d].p = keep_p;
            end else if (sch_cyc[d][s] == t) begin
                sch_cyc[d][s] = -1;
                mdl[d].v = 1'b1;
                mdl[d].p = sch_ok[d][s];
                if (sch_ok[d][s]) begin
                    if (int'(mdl[d].pc) < cmax[d]) mdl[d].pc = mdl[d].pc + 8'd1;
                end else begin
                    if (int'(mdl[d].ec) < cmax[d]) mdl[d].ec = mdl[d].ec + 8'd1;
`ifdef FA4CHK_FAIL_CAPTURE_EN
                    if (!mdl[d].st) begin
                        v = sch_vec[d][s];
                        r = resp(v);
                        mdl[d].fa  = v.a;
                        mdl[d].fb  = v.b;
                        mdl[d].fci = v.cin;
                        mdl[d].fs  = r[3:0];
                        mdl[d].fco = r[4];
                    end
`endif
                    mdl[d].st = 1'b1;
                end
            end else begin
                mdl[d].v = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== '0) $display("FAIL reset d%0d got=%h want=0", d, obs[d]);
            else passed++;
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        set_in(1, 4'd1, 4'd2, 0, 4'd0, 0);
        step();
        set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
        step();
        total++;
        if ({cv0, cp0, pc0, ec0} !== {1'b1, 1'b1, 8'd1, 8'd0})
            $display("FAIL basic_lat1 got v=%b p=%b pc=%0d ec=%0d want 1 1 1 0", cv0, cp0, pc0, ec0);
        else passed++;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs[d] !== mdl[d]) $display("FAIL basic d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
            else passed++;
        end
    endtask

    task automatic test_carry_fail();
        logic [17:0] want;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      set_in(1, 4'd15, 4'd1, 0, 4'd0, 0);
            else if (i == 1) set_in(1, 4'd15, 4'd1, 0, 4'd0, 1);
            else             set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL carry d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
`ifdef FA4CHK_FAIL_CAPTURE_EN
        want = {8'd1, 1'b1, 4'd15, 4'd1, 4'd0, 1'b0};
`else
        want = {8'd1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0};
`endif
        total++;
        if ({ec0, st0, fa0, fb0, fs0, fco0} !== want)
            $display("FAIL carry_capture got=%h want=%h", {ec0, st0, fa0, fb0, fs0, fco0}, want);
        else passed++;
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: set_in(1, 4'd2, 4'd3, 0, 4'd0, 0);
                1: set_in(1, 4'd4, 4'd5, 0, 4'd0, 0);
                2: set_in(1, 4'd6, 4'd7, 1, 4'd0, 0);
                default: set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            endcase
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL b2b d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        total++;
        if ({pc1, ec1, st1} !== {8'd3, 8'd0, 1'b0})
            $display("FAIL b2b_lat3 got pc=%0d ec=%0d st=%b want 3 0 0", pc1, ec1, st1);
        else passed++;
    endtask

    task automatic test_double_fail_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      set_in(1, 4'd2, 4'd3, 0, 4'd1, 0);
            else if (i == 1) set_in(1, 4'd4, 4'd5, 0, 4'd2, 0);
            else             set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL dfail d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        total++;
`ifdef FA4CHK_FAIL_CAPTURE_EN
        if ({ec0, fa0, fb0} !== {8'd2, 4'd2, 4'd3})
`else
        if ({ec0, fa0, fb0} !== {8'd2, 4'd0, 4'd0})
`endif
            $display("FAIL dfail_keep got ec=%0d fa=%0d fb=%0d", ec0, fa0, fb0);
        else passed++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({obs[d].v, obs[d].pc, obs[d].ec, obs[d].st, obs[d].fa, obs[d].fb, obs[d].fs} !== '0)
                $display("FAIL clear d%0d got=%h want zeros", d, obs[d]);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) set_in(1, 4'(i), 4'(i + 3), i[0], 4'd0, 0);
            else       set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL sat d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        total++;
        if (pc2 !== 2'd3) $display("FAIL sat_cnt got=%0d want=3", pc2);
        else passed++;
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 7; i++) begin
            reset = (i == 1);
            if (i == 0) set_in(1, 4'd9, 4'd9, 1, 4'd0, 0);
            else        set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            step();
            if (i == 1) begin
                total++;
                if ({obs[0], obs[1]} !== '0) $display("FAIL rst_flight got=%h want=0", {obs[0], obs[1]});
                else passed++;
            end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL rstfl d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_clear_with_valid();
        for (int i = 0; i < 6; i++) begin
            clear = (i < 2);
            if (i == 1) set_in(1, 4'd3, 4'd4, 0, 4'd0, 0);
            else        set_in(0, 4'd0, 4'd0, 0, 4'd0, 0);
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL clrv d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        clear = 1'b0;
        total++;
        if ({cv2, pc2, pc0, pc1} !== '0) $display("FAIL clrv_drop got pc=%0d/%0d/%0d want 0", pc0, pc1, pc2);
        else passed++;
    endtask

    task automatic test_random();
        bit v, inj, xc;
        logic [3:0] xs;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(3) != 0);
            inj = ($urandom_range(7) == 0);
            xs  = inj ? 4'($urandom_range(15)) : 4'd0;
            xc  = inj ? 1'($urandom_range(1)) : 1'b0;
            if (inj && xs == 4'd0) xc = 1'b1;
            clear = ($urandom_range(39) == 0);
            set_in(v, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)), xs, xc);
            step();
            for (int d = 0; d < 3; d++) begin
                total++;
                if (obs[d] !== mdl[d]) $display("FAIL rand d%0d cyc=%0d got=%h want=%h", d, t, obs[d], mdl[d]);
                else passed++;
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            mdl[d] = '0;
            for (int k = 0; k < 16; k++) sch_cyc[d][k] = -1;
        end
        test_reset();
        test_basic();
        test_carry_fail();
        test_back_to_back();
        test_double_fail_clear();
        test_saturation();
        test_reset_inflight();
        test_clear_with_valid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", t);
        $fatal(1);
    end

endmodule

// File: doc/fulladd4_resp_checker.md
# fulladd4_resp_checker

Synthesizable response checker for the 4-bit ripple adder `fulladd4`. It sits on the output side of the adder: it accepts the same operand stream that drives the adder and computes the golden result internally. It delays that result to align with the adder's response, then compares it against the adder's `SUM` and `C_OUT`. Pass/fail counts, a sticky error flag and a capture of the first failing vector give on-chip self-check without a simulator monitor.

## Interface
- `WIDTH`, 4, operand/sum width
- `LAT`, 1, cycles from operand presentation to adder response valid at `dut_sum`/`dut_cout`; legal 0..7
- `CNT_W`, 8, width of pass/error counters
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, one reset, no other clock domains
- `in_valid`  in  1  operand vector present this cycle
- `in_a`  in  WIDTH  operand A
- `in_b`  in  WIDTH  operand B
- `in_cin`  in  1  carry in
- `dut_sum`  in  WIDTH  adder SUM
- `dut_cout`  in  1  adder C_OUT
- `clear`  in  1  synchronous clear of counters, sticky flag, capture and pipeline
- `chk_valid`  out  1  one-cycle pulse: a compare result is on `chk_pass`
- `chk_pass`  out  1  result of that compare (1 = match)
- `pass_cnt`  out  CNT_W  matching compares, saturating
- `err_cnt`  out  CNT_W  mismatching compares, saturating
- `err_sticky`  out  1  set on first mismatch, held until reset/clear
- `fail_a`, `fail_b`  out  WIDTH  operands of first mismatch
- `fail_cin`  out  1  carry-in of first mismatch
- `fail_sum`  out  WIDTH  adder SUM of first mismatch
- `fail_cout`  out  1  adder C_OUT of first mismatch

## Operation
- Golden result: `exp = in_a + in_b + in_cin`, computed at WIDTH+1 bits. `exp[WIDTH]` is the expected carry and `exp[WIDTH-1:0]` is the expected sum. No truncation before compare.
- Alignment pipeline: LAT stages, each holding {valid, a, b, cin, exp}. Stage 0 loads from the inputs every cycle; a stage whose valid bit is 0 is a bubble, and bubbles are passed through.
- Compare point: the output of the last stage. For LAT=0 the compare point is the inputs themselves. When the compare point is valid, `{dut_cout, dut_sum}` is compared against `exp` in that same cycle.
- Result register: `chk_valid`, `chk_pass` and the counters update on the edge that follows the compare cycle.
- Counters: increment `pass_cnt` on a match and `err_cnt` on a mismatch. Each counter saturates at 2^CNT_W−1 and never wraps.
- Sticky: `err_sticky` sets on the first mismatch. The fail capture loads only when `err_sticky` is 0, so later mismatches do not overwrite it.
- `clear`: zeroes counters, sticky, capture and all pipeline valid bits. In-flight vectors are discarded.
- `clear` together with `in_valid`: the new vector is dropped.
- `reset` has priority over `clear`.
- No backpressure. The block accepts a vector every cycle and never stalls.

## Timing
- Reset values: `chk_valid`=0, `chk_pass`=0, `pass_cnt`=0, `err_cnt`=0, `err_sticky`=0, all `fail_*`=0, and all pipeline valid bits=0.
- Latency: `in_valid` at cycle N gives a `chk_valid` pulse at cycle N+LAT+1. Throughput is 1 vector/cycle.
- `chk_pass` is meaningful only while `chk_valid`=1. It holds its last value otherwise.
- `err_sticky` and the `fail_*` outputs update in the same cycle as the `chk_valid` pulse of the first mismatch.
- Reset mid-stream: all in-flight vectors are lost and no `chk_valid` pulse is produced for them.

## Configuration
- Macro: `FA4CHK_FAIL_CAPTURE_EN`.
- Defined: the `fail_*` registers exist and behave as described above.
- Undefined: no capture registers are built and all `fail_*` outputs are tied to 0. `err_sticky`, the counters and `chk_*` are unaffected.

## Test plan
- LAT=1, a=1, b=2, cin=0, adder SUM=3 and C_OUT=0 one cycle later -> `chk_valid` pulse 2 cycles after input, `chk_pass`=1, `pass_cnt`=1, `err_cnt`=0.
- Carry-out case a=15, b=1, cin=0, adder returns SUM=0, C_OUT=1 -> pass. Then force C_OUT=0 on a=15, b=1 -> `err_cnt`=1, `err_sticky`=1, `fail_a`=15, `fail_b`=1, `fail_sum`=0, `fail_cout`=0.
- Back-to-back vectors (2,3,0), (4,5,0), (6,7,1) with a correct adder, LAT=3 -> three consecutive `chk_valid` pulses at cycles N+4..N+6, all pass, `pass_cnt`=3.
- Two mismatches, on (2,3,0) then (4,5,0) -> `fail_a`=2, `fail_b`=3 are retained and `err_cnt`=2. Then `clear` -> all counters and capture return to 0.
- CNT_W=2, six matching vectors -> `pass_cnt` saturates at 3. `reset` asserted while a vector is in flight -> no `chk_valid` pulse for that vector, and all outputs are at reset values the cycle after.
- Build without `FA4CHK_FAIL_CAPTURE_EN`, inject a mismatch -> `err_sticky`=1, `err_cnt`=1, all `fail_*`=0.
